// File: rtl/calc_ctrl.sv
// Key-entry front end for the 4-bit combinational calculator: collects A, opcode
// and B over a valid/ready handshake, captures the result and hands it off downstream.
module calc_ctrl #(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned TW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic [3:0]    key_data,
    output logic [3:0]    calc_a,
    output logic [3:0]    calc_b,
    output logic [2:0]    calc_s,
    input  logic [4:0]    calc_y,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [4:0]    res_data,
    output logic          res_err,
    output logic          timeout,
    output logic [7:0]    ops_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_OP = 3'd1,
        WAIT_B  = 3'd2,
        EXEC    = 3'd3,
        RESULT  = 3'd4
    } state_t;

    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [TW-1:0] timer_reg;
    logic [TW-1:0] timer_next;

    logic [3:0]    calc_a_reg;
    logic [3:0]    calc_b_reg;
    logic [2:0]    calc_s_reg;
    logic [4:0]    res_data_reg;
    logic          res_err_reg;
    logic          res_valid_reg;
    logic          timeout_reg;
    logic [7:0]    ops_done_reg;

    logic          transfer;
    logic          in_wait;
    logic          timeout_hit;
    logic          res_take;

    assign transfer    = key_valid && key_ready;
    assign in_wait     = (state_reg == WAIT_OP) || (state_reg == WAIT_B);
    assign timeout_hit = (TIMEOUT != 0) && in_wait && !transfer && (timer_reg == TIMER_LAST);
    // The hand-off completes only once the result is actually being presented.
    assign res_take    = (state_reg == RESULT) && res_valid_reg && res_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and timer logic
    always_comb begin
        state_next = state_reg;
        timer_next = '0;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (transfer) state_next = WAIT_OP;
                end
                WAIT_OP: begin
                    if (transfer)         state_next = WAIT_B;
                    else if (timeout_hit) state_next = IDLE;
                end
                WAIT_B: begin
                    if (transfer)         state_next = EXEC;
                    else if (timeout_hit) state_next = IDLE;
                end
                EXEC: begin
                    state_next = RESULT;
                end
                RESULT: begin
                    if (res_take) state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
            if (in_wait && !transfer && !timeout_hit) begin
                timer_next = timer_reg + 1'b1;
            end
        end
    end

    // Output decode: key_ready depends on state only
    always_comb begin
        key_ready = (state_reg == IDLE) || (state_reg == WAIT_OP) || (state_reg == WAIT_B);
    end

    // Datapath registers; clr leaves operands and the last result untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg     <= '0;
            calc_a_reg    <= '0;
            calc_b_reg    <= '0;
            calc_s_reg    <= '0;
            res_data_reg  <= '0;
            res_err_reg   <= 1'b0;
            res_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            ops_done_reg  <= '0;
        end else begin
            timer_reg     <= timer_next;
            // Valid trails RESULT entry by one cycle and drops on the hand-off edge.
            res_valid_reg <= !clr && (state_reg == RESULT) && !res_take;
            timeout_reg   <= !clr && timeout_hit;
            if (!clr) begin
                if (transfer && (state_reg == IDLE))    calc_a_reg <= key_data;
                if (transfer && (state_reg == WAIT_OP)) calc_s_reg <= key_data[2:0];
                if (transfer && (state_reg == WAIT_B))  calc_b_reg <= key_data;
                if (state_reg == EXEC) begin
                    res_data_reg <= calc_y;
                    res_err_reg  <= (calc_s_reg > 3'd5);
                end
                if (res_take) ops_done_reg <= ops_done_reg + 8'd1;
            end
        end
    end

    assign calc_a    = calc_a_reg;
    assign calc_b    = calc_b_reg;
    assign calc_s    = calc_s_reg;
    assign res_data  = res_data_reg;
    assign res_err   = res_err_reg;
    assign res_valid = res_valid_reg;
    assign timeout   = timeout_reg;
    assign ops_done  = ops_done_reg;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl with a behavioural calculator (add, sub, and, or,
// compare, xor; opcodes 6/7 give 0) wired to calc_a/b/s -> calc_y.
module tb_calc_ctrl;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] key_data;
    logic [3:0] calc_a;
    logic [3:0] calc_b;
    logic [2:0] calc_s;
    logic [4:0] calc_y;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_data;
    logic       res_err;
    logic       timeout;
    logic [7:0] ops_done;

    int         n_tests;
    int         n_fail;
    logic [7:0] exp_ops;

    calc_ctrl #(.TIMEOUT(4), .TW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_data  (key_data),
        .calc_a    (calc_a),
        .calc_b    (calc_b),
        .calc_s    (calc_s),
        .calc_y    (calc_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .timeout   (timeout),
        .ops_done  (ops_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Calculator model; opcode 4 is a one-hot compare {eq, gt, lt}
    always_comb begin
        case (calc_s)
            3'd0:    calc_y = {1'b0, calc_a} + {1'b0, calc_b};
            3'd1:    calc_y = {1'b0, calc_a} - {1'b0, calc_b};
            3'd2:    calc_y = {1'b0, calc_a & calc_b};
            3'd3:    calc_y = {1'b0, calc_a | calc_b};
            3'd4:    calc_y = {2'b00, calc_a == calc_b, calc_a > calc_b, calc_a < calc_b};
            3'd5:    calc_y = {1'b0, calc_a ^ calc_b};
            default: calc_y = 5'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        key_valid = 1'b1;
        key_data  = d;
        tick();
        key_valid = 1'b0;
    endtask

    // Full sequence with res_ready already high; B is accepted at edge N
    task automatic do_op(input logic [3:0] a, input logic [3:0] op, input logic [3:0] b,
                         input logic [4:0] y, input logic err);
        logic [2:0] op_lo;
        op_lo = op[2:0];
        send(a);
        check("calc_a", calc_a, a);
        send(op);
        check("calc_s", calc_s, op_lo);
        send(b);
        check("calc_b", calc_b, b);
        check("exec_key_ready", key_ready, 0);
        check("exec_res_valid", res_valid, 0);
        tick();
        check("n1_res_valid", res_valid, 0);
        check("n1_key_ready", key_ready, 0);
        tick();
        check("n2_res_valid", res_valid, 1);
        check("res_data", res_data, y);
        check("res_err", res_err, err);
        check("result_key_ready", key_ready, 0);
        tick();
        exp_ops = exp_ops + 8'd1;
        check("handoff_res_valid", res_valid, 0);
        check("ops_done", ops_done, exp_ops);
        check("idle_key_ready", key_ready, 1);
        $display("[TB] op a=%0h s=%0h b=%0h -> res_data=%0h res_err=%0b ops_done=%0d",
                 a, op_lo, b, res_data, res_err, ops_done);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_calc_a"}, calc_a, 0);
        check({tag, "_calc_b"}, calc_b, 0);
        check({tag, "_calc_s"}, calc_s, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_res_err"}, res_err, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_ops_done"}, ops_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_ops   = 8'd0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        key_valid = 1'b0;
        key_data  = 4'd0;
        res_ready = 1'b0;

        // Reset state
        #12;
        check_all_zero("reset");
        check("reset_key_ready", key_ready, 1);
        rst_n = 1'b1;
        tick();

        // Main function, several opcodes
        res_ready = 1'b1;
        do_op(4'd9, 4'd0, 4'd8, 5'h11, 1'b0);
        do_op(4'd3, 4'd1, 4'd5, 5'h1E, 1'b0);
        do_op(4'd7, 4'd4, 4'd7, 5'b00100, 1'b0);
        do_op(4'd9, 4'd4, 4'd2, 5'b00010, 1'b0);
        do_op(4'd1, 4'hE, 4'd1, 5'd0, 1'b1);

        // Result backpressure with keys offered
        res_ready = 1'b0;
        send(4'd4);
        send(4'd2);
        send(4'd3);
        tick();
        tick();
        check("bp_res_valid", res_valid, 1);
        check("bp_res_data", res_data, 5'd0);
        check("bp_res_err", res_err, 0);
        key_valid = 1'b1;
        key_data  = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_data", res_data, 5'd0);
            check("bp_hold_key_ready", key_ready, 0);
            check("bp_hold_calc_a", calc_a, 4'd4);
        end
        $display("[TB] backpressure 10 cycles res_valid=%0b res_data=%0h", res_valid, res_data);
        key_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        exp_ops = exp_ops + 8'd1;
        check("bp_release_valid", res_valid, 0);
        check("bp_release_ops", ops_done, exp_ops);

        // Back-to-back A, then let it time out
        send(4'hA);
        check("b2b_calc_a", calc_a, 4'hA);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_pre", timeout, 0);
        end
        tick();
        check("to_pulse", timeout, 1);
        tick();
        check("to_after", timeout, 0);
        $display("[TB] timeout after A=a pulse seen");
        send(4'd6);
        check("to_idle_calc_a", calc_a, 4'd6);
        check("to_idle_calc_s", calc_s, 3'd2);

        // Opcode arriving in the last allowed cycle wins over the timeout
        for (int i = 0; i < 3; i++) begin
            tick();
            check("late_pre", timeout, 0);
        end
        send(4'd1);
        check("late_timeout", timeout, 0);
        check("late_calc_s", calc_s, 3'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("late_waitb", timeout, 0);
        end
        $display("[TB] late opcode accepted calc_s=%0h", calc_s);

        // clr in WAIT_B, coinciding with a B key and a due timeout
        clr       = 1'b1;
        key_valid = 1'b1;
        key_data  = 4'd9;
        tick();
        clr       = 1'b0;
        key_valid = 1'b0;
        check("clrb_calc_b", calc_b, 4'd3);
        check("clrb_res_valid", res_valid, 0);
        check("clrb_timeout", timeout, 0);
        check("clrb_ops", ops_done, exp_ops);
        send(4'd5);
        check("clrb_idle_calc_a", calc_a, 4'd5);
        $display("[TB] clr in WAIT_B calc_b=%0h calc_a=%0h", calc_b, calc_a);

        // clr in RESULT with res_ready high
        res_ready = 1'b0;
        send(4'd0);
        send(4'd2);
        tick();
        tick();
        check("clrr_res_valid_pre", res_valid, 1);
        check("clrr_res_data_pre", res_data, 5'd7);
        clr       = 1'b1;
        res_ready = 1'b1;
        tick();
        clr       = 1'b0;
        check("clrr_res_valid", res_valid, 0);
        check("clrr_ops", ops_done, exp_ops);
        check("clrr_res_data", res_data, 5'd7);
        check("clrr_key_ready", key_ready, 1);
        $display("[TB] clr in RESULT res_valid=%0b ops_done=%0d", res_valid, ops_done);

        // Asynchronous reset mid-sequence
        send(4'd5);
        send(4'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async");
        #3 rst_n = 1'b1;
        exp_ops = 8'd0;
        $display("[TB] async reset mid-sequence ops_done=%0d", ops_done);
        tick();
        do_op(4'd2, 4'd0, 4'd3, 5'd5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
